// File: rtl/result_uart_dumper.sv
// result_uart_dumper: reads NUM_SAMPLES bytes from the result RAM (address 0 upward) and sends each as an 8N1 UART frame.
// Latency: first start bit RAM_LAT cycles after start; each byte occupies RAM_LAT + 10*CLKS_PER_BIT cycles.
// Backpressure: none; the line is free-running, start is ignored while busy, abort returns to idle on the next cycle.
module result_uart_dumper #(
   parameter int CLKS_PER_BIT = 434,
   parameter int NUM_SAMPLES  = 255,
   parameter int data_bits    = 8,
   parameter int addr_bits    = 8,
   parameter int RAM_LAT      = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   output logic [addr_bits-1:0] ram_rdaddr,
   input  logic [data_bits-1:0] ram_q,
   output logic                 tx,
   output logic                 busy,
   output logic                 done,
   output logic [addr_bits-1:0] byte_count
);

   // One counter times both the FETCH wait and every UART bit, so it must reach the larger of the two.
   localparam int CNT_MAX = (CLKS_PER_BIT > RAM_LAT) ? CLKS_PER_BIT : RAM_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0]     BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]     FETCH_LAST = CNT_W'(RAM_LAT - 1);
   localparam logic [addr_bits-1:0] LAST_IDX   = addr_bits'(NUM_SAMPLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [data_bits-1:0]   sh_q, sh_d;
   logic [addr_bits-1:0]   ram_rdaddr_q, ram_rdaddr_d;
   logic [addr_bits-1:0]   byte_count_q, byte_count_d;
   logic                   tx_q, tx_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   // Next-state and next-output computation; tx is decided one cycle ahead so the pin comes straight from a flop.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + CNT_W'(1);
      bit_cnt_d    = bit_cnt_q;
      sh_d         = sh_q;
      ram_rdaddr_d = ram_rdaddr_q;
      byte_count_d = byte_count_q;
      tx_d         = tx_q;
      busy_d       = busy_q;
      done_d       = done_q;

      if (abort && (state_q != S_IDLE)) begin
         // Abort drops the frame in flight; done is left alone so a partial dump never looks complete.
         state_d      = S_IDLE;
         cnt_d        = '0;
         bit_cnt_d    = '0;
         ram_rdaddr_d = '0;
         byte_count_d = '0;
         tx_d         = 1'b1;
         busy_d       = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               cnt_d  = '0;
               tx_d   = 1'b1;
               busy_d = 1'b0;
               if (start && !abort) begin
                  state_d      = S_FETCH;
                  ram_rdaddr_d = '0;
                  byte_count_d = '0;
                  busy_d       = 1'b1;
                  done_d       = 1'b0;
               end
            end
            S_FETCH: begin
               tx_d = 1'b1;
               if (cnt_q == FETCH_LAST) begin
                  sh_d    = ram_q;
                  state_d = S_START;
                  cnt_d   = '0;
                  tx_d    = 1'b0;
               end
            end
            S_START: begin
               if (cnt_q == BIT_LAST) begin
                  state_d   = S_DATA;
                  cnt_d     = '0;
                  bit_cnt_d = '0;
                  tx_d      = sh_q[0];
               end
            end
            S_DATA: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_d = '0;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                     sh_d      = sh_q >> 1;
                     tx_d      = sh_q[1];
                  end
               end
            end
            S_STOP: begin
               tx_d = 1'b1;
               if (cnt_q == BIT_LAST) begin
                  cnt_d = '0;
                  if (byte_count_q == LAST_IDX) begin
                     state_d      = S_IDLE;
                     ram_rdaddr_d = '0;
                     busy_d       = 1'b0;
                     done_d       = 1'b1;
                  end else begin
                     state_d      = S_FETCH;
                     ram_rdaddr_d = ram_rdaddr_q + addr_bits'(1);
                     byte_count_d = byte_count_q + addr_bits'(1);
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   // State and output registers; asynchronous reset forces the line idle-high at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         bit_cnt_q    <= '0;
         sh_q         <= '0;
         ram_rdaddr_q <= '0;
         byte_count_q <= '0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         sh_q         <= sh_d;
         ram_rdaddr_q <= ram_rdaddr_d;
         byte_count_q <= byte_count_d;
         tx_q         <= tx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign ram_rdaddr = ram_rdaddr_q;
   assign byte_count = byte_count_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_result_uart_dumper.sv
// tb_result_uart_dumper: drives two dumpers (RAM_LAT 1 and 2) and decodes their UART output against the RAM contents.
// Latency: expected dump time is NUM_SAMPLES*(10*CLKS_PER_BIT+RAM_LAT) cycles from the start cycle.
// Backpressure: none; abort and asynchronous reset are injected at fixed and random points.
module tb_result_uart_dumper;
   localparam int C     = 4;
   localparam int N     = 3;
   localparam int FRAME = 10 * C;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start1 = 1'b0, abort1 = 1'b0, start2 = 1'b0, abort2 = 1'b0;
   logic [7:0] addr1, addr2, q1, q2, bc1, bc2;
   logic       tx1, tx2, busy1, busy2, done1, done2;
   logic [7:0] mem [0:255];
   int         sel = 0;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM models: zero-wait read of the registered address, and one extra register stage.
   assign q1 = mem[addr1];
   always @(posedge clk) q2 <= mem[addr2];

   result_uart_dumper #(.CLKS_PER_BIT(C), .NUM_SAMPLES(N), .data_bits(8), .addr_bits(8), .RAM_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1), .ram_rdaddr(addr1), .ram_q(q1),
      .tx(tx1), .busy(busy1), .done(done1), .byte_count(bc1));

   result_uart_dumper #(.CLKS_PER_BIT(C), .NUM_SAMPLES(N), .data_bits(8), .addr_bits(8), .RAM_LAT(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort2), .ram_rdaddr(addr2), .ram_q(q2),
      .tx(tx2), .busy(busy2), .done(done2), .byte_count(bc2));

   wire       tx_m   = (sel == 1) ? tx2   : tx1;
   wire       busy_m = (sel == 1) ? busy2 : busy1;
   wire       done_m = (sel == 1) ? done2 : done1;
   wire [7:0] addr_m = (sel == 1) ? addr2 : addr1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // UART receiver: captures whole frames sample by sample, then judges shape and extracts the byte.
   logic       dec_on = 1'b0;
   bit         in_frame = 1'b0;
   int         k = 0;
   int         fs_cur = 0;
   logic       smp [0:FRAME-1];
   logic [7:0] dec_b;
   bit         dec_ok;
   logic [7:0] rx_q [$];
   int         fs_q [$];
   bit         ok_q [$];

   always @(negedge clk) begin
      if (!dec_on) begin
         in_frame = 1'b0;
      end else if (!in_frame) begin
         if (tx_m === 1'b0) begin
            in_frame = 1'b1;
            smp[0]   = 1'b0;
            k        = 1;
            fs_cur   = cyc;
         end
      end else begin
         smp[k] = tx_m;
         k++;
         if (k == FRAME) begin
            dec_ok = 1'b1;
            for (int j = 0; j < FRAME; j++) begin
               if (j < C) begin
                  if (smp[j] !== 1'b0) dec_ok = 1'b0;
               end else if (j >= 9 * C) begin
                  if (smp[j] !== 1'b1) dec_ok = 1'b0;
               end else if (smp[j] !== smp[C * (j / C)]) begin
                  dec_ok = 1'b0;
               end
            end
            for (int i = 0; i < 8; i++) dec_b[i] = smp[C * (i + 1)];
            rx_q.push_back(dec_b);
            fs_q.push_back(fs_cur);
            ok_q.push_back(dec_ok);
            in_frame = 1'b0;
         end
      end
   end

   task automatic set_start(input int s, input logic v);
      if (s == 1) start2 = v; else start1 = v;
   endtask

   task automatic set_abort(input int s, input logic v);
      if (s == 1) abort2 = v; else abort1 = v;
   endtask

   // Complete dump: every byte, its frame shape, frame spacing and the done instant come from the RAM contents and timing rules.
   task automatic run_dump(input int s, input bit ign);
      int lat, total, t0, t_done, busy_drop;
      bit seen;
      lat   = (s == 1) ? 2 : 1;
      total = N * (FRAME + lat);
      sel   = s;
      rx_q.delete(); fs_q.delete(); ok_q.delete();
      @(negedge clk);
      dec_on = 1'b1;
      set_start(s, 1'b1);
      @(negedge clk);
      set_start(s, 1'b0);
      t0 = cyc;
      check("busy_after_start", busy_m, 1);
      check("done_cleared", done_m, 0);
      seen = 1'b0; t_done = 0; busy_drop = 0;
      for (int i = 0; i < total + 200 && !seen; i++) begin
         if (ign && i == 50) set_start(s, 1'b1);
         if (ign && i == 51) set_start(s, 1'b0);
         @(negedge clk);
         if (done_m === 1'b1) begin
            seen   = 1'b1;
            t_done = cyc;
         end else if (busy_m !== 1'b1) begin
            busy_drop++;
         end
      end
      set_start(s, 1'b0);
      if (!seen) check("done_timeout", 0, 1);
      else check("done_time", t_done - t0, total);
      check("busy_held", busy_drop, 0);
      check("busy_clear", busy_m, 0);
      check("addr_wrap", addr_m, 0);
      repeat (3) @(negedge clk);
      check("done_sticky", done_m, 1);
      check("n_bytes", rx_q.size(), N);
      for (int i = 0; i < N && i < rx_q.size(); i++) begin
         check($sformatf("byte%0d", i), rx_q[i], mem[i]);
         check($sformatf("frame_shape%0d", i), ok_q[i], 1);
         if (i == 0) check("first_start_bit", fs_q[0] - t0, lat);
         else check($sformatf("frame_period%0d", i), fs_q[i] - fs_q[i-1], FRAME + lat);
      end
      dec_on = 1'b0;
   endtask

   // Start a dump, raise abort so it is sampled off cycles after the start cycle, and check the return to idle.
   task automatic abort_at(input int s, input int off);
      int t0;
      sel = s;
      dec_on = 1'b0;
      @(negedge clk);
      set_start(s, 1'b1);
      @(negedge clk);
      set_start(s, 1'b0);
      t0 = cyc;
      while (cyc < t0 + off - 1) @(negedge clk);
      set_abort(s, 1'b1);
      @(negedge clk);
      set_abort(s, 1'b0);
      check("abort_tx", tx_m, 1);
      check("abort_busy", busy_m, 0);
      check("abort_done", done_m, 0);
      check("abort_addr", addr_m, 0);
      repeat (5) @(negedge clk);
      check("abort_stays_idle", busy_m, 0);
   endtask

   // Start a dump and assert reset between clock edges off cycles in; outputs must fall back without any edge.
   task automatic reset_at(input int s, input int off);
      int t0;
      sel = s;
      dec_on = 1'b0;
      @(negedge clk);
      set_start(s, 1'b1);
      @(negedge clk);
      set_start(s, 1'b0);
      t0 = cyc;
      while (cyc < t0 + off) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("rst_tx", tx_m, 1);
      check("rst_busy", busy_m, 0);
      check("rst_done", done_m, 0);
      check("rst_addr", addr_m, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF;
      for (int i = 3; i < 256; i++) mem[i] = 8'h00;

      #2 rst = 1'b0;
      #1;
      check("reset_tx", tx1, 1);
      check("reset_busy", busy1, 0);
      check("reset_done", done1, 0);
      check("reset_addr", addr1, 0);
      check("reset_bytecount", bc1, 0);
      check("reset_tx_lat2", tx2, 1);
      check("reset_bytecount_lat2", bc2, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_tx", tx1, 1);
         check("idle_busy", busy1, 0);
         check("idle_done", done1, 0);
         check("idle_addr", addr1, 0);
      end

      run_dump(0, 1'b0);
      run_dump(0, 1'b1);

      // start and abort together in idle: abort wins
      sel = 0;
      @(negedge clk);
      start1 = 1'b1; abort1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; abort1 = 1'b0;
      check("start_abort_idle_busy", busy1, 0);
      check("start_abort_idle_done", done1, 1);
      repeat (3) @(negedge clk);
      check("start_abort_idle_tx", tx1, 1);

      abort_at(0, 50);
      run_dump(0, 1'b0);

      reset_at(0, 120);
      run_dump(0, 1'b0);

      run_dump(1, 1'b0);

      for (int it = 0; it < 8; it++) begin
         int s, act, off;
         s   = $urandom_range(0, 1);
         act = $urandom_range(0, 2);
         off = $urandom_range(1, N * (FRAME + s + 1) - 1);
         for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
         if (act == 1) abort_at(s, off);
         else if (act == 2) reset_at(s, off);
         run_dump(s, act == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/result_uart_dumper.md
Name: result_uart_dumper

Overview:
- Reads filtered samples back out of the result RAM after a filter run and streams them to a host PC over a UART TX line (8N1, LSB first).
- The filter run writes the results into the result RAM. This block is the reader at the other end of that RAM and replaces manual button stepping for bulk readout.
- It drives the RAM read address and serialises one byte per address, from address 0 up to NUM_SAMPLES-1.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 2
- NUM_SAMPLES, 255, number of result words to dump; must be >= 1 and <= 2^addr_bits
- data_bits, 8, RAM word width; fixed at 8 for UART framing
- addr_bits, 8, RAM address width
- RAM_LAT, 1, clk cycles from ram_rdaddr change to valid ram_q; must be >= 1

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- start  input  1  synchronous pulse; begins a dump when in IDLE
- abort  input  1  synchronous; terminates the dump immediately
- ram_rdaddr  output  addr_bits  result RAM read address
- ram_q  input  data_bits  result RAM read data
- tx  output  1  UART serial out; idles high
- busy  output  1  high from accepting start until return to IDLE
- done  output  1  sticky; set when the last byte's stop bit completes
- byte_count  output  addr_bits  index of the byte currently being sent or fetched

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx=1, busy=0, done=0, ram_rdaddr=0, byte_count=0, bit and baud counters=0, shift register=0.
- Reset asserted mid-frame: tx returns to 1 immediately. No partial frame completes. The next dump after release restarts at address 0.
- States: IDLE, FETCH, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - On start=1: clear done, set ram_rdaddr=0 and byte_count=0, set busy=1, go to FETCH.
  - start while busy=1 is ignored.
- FETCH:
  - Hold for exactly RAM_LAT cycles; tx=1.
  - On the final FETCH cycle, latch ram_q into the shift register and go to START.
- START: tx=0 for exactly CLKS_PER_BIT cycles.
- DATA:
  - 8 bits, LSB first, each bit held exactly CLKS_PER_BIT cycles.
  - The shift register shifts right at each bit boundary.
  - A 3-bit counter tracks bits 0..7.
- STOP: tx=1 for exactly CLKS_PER_BIT cycles. At the end of STOP:
  - If byte_count == NUM_SAMPLES-1: go to IDLE, set done=1, busy=0. ram_rdaddr wraps to 0.
  - Otherwise: increment ram_rdaddr and byte_count, go to FETCH.
- Timing:
  - Frame length: 10*CLKS_PER_BIT cycles.
  - Inter-frame gap: RAM_LAT cycles of tx=1.
  - Total dump time from the start cycle to the done rising edge: NUM_SAMPLES*(10*CLKS_PER_BIT+RAM_LAT) cycles.
- Baud counter counts 0..CLKS_PER_BIT-1 and is cleared on every state entry. No fractional-baud correction.
- abort=1 in any non-IDLE state: next cycle state=IDLE, tx=1, busy=0, done unchanged (stays 0), ram_rdaddr=0. abort has priority over start in the same cycle.
- start and abort both high in IDLE: abort wins; the dump does not start.
- ram_rdaddr is stable throughout FETCH..STOP of a byte, so the RAM may be single-port registered.
- done stays high until the next accepted start or reset.
- All outputs are registered. tx comes from a flop (no glitches).

Test Plan:
- Reset and idle (CLKS_PER_BIT=4, RAM_LAT=1, NUM_SAMPLES=3, RAM model [0xA5,0x3C,0xFF]): release rst and wait 20 cycles -> tx=1, busy=0, done=0, ram_rdaddr=0 throughout.
- Full dump, same setup:
  - Pulse start -> busy=1 the next cycle.
  - Bench UART decoder receives 0xA5, 0x3C, 0xFF in order, each frame 40 cycles.
  - done rises exactly 123 cycles after the start cycle; ram_rdaddr back to 0.
- Bit timing: first frame (0xA5) -> start-bit low 4 cycles, then tx bit pattern 1,0,1,0,0,1,0,1 each 4 cycles, then stop high 4 cycles.
- Ignored start: pulse start again 50 cycles into the dump -> byte stream and done timing identical to the uninterrupted dump.
- Abort: assert abort during DATA of byte 1 (0x3C) -> tx=1 and busy=0 the next cycle, done=0. A subsequent start re-sends from 0xA5.
- Async reset mid-STOP of byte 2 -> tx=1 and busy=0 without a clk edge. After release and start, the full three-byte sequence is repeated. Also run with RAM_LAT=2 -> same bytes, gap 2 cycles, total 126 cycles.
